int_to_ieee754: RTL and testbench
=================================

INT_TO_IEEE754 -- requirements
Module: int_to_ieee754

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, in_int/in_signed valid.
REQ-004 SHALL have port in_ready, output, 1, converter accepts input this cycle.
REQ-005 SHALL have port in_int, input, 32, integer operand.
REQ-006 SHALL have port in_signed, input, 1, 1 = two's complement, 0 = unsigned.
REQ-007 SHALL have port out_valid, output, 1, out_float valid.
REQ-008 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-009 SHALL have port out_float, output, 32, normalized IEEE-754 single, suitable as adder_floating_point operand.
REQ-010 SHALL have port zero, output, 1, result is +0; valid with out_valid.
REQ-011 SHALL have port inexact, output, 1, rounding discarded nonzero bits; valid with out_valid.

Function
REQ-012 SHALL implement FSM states IDLE, ABS, NORM, ROUND, DONE.
REQ-013 in_ready SHALL be 1 only in IDLE; transfer on in_valid & in_ready captures in_int, in_signed; next state ABS.
REQ-014 ABS: sign = in_signed & in_int[31]; mag = sign ? -in_int : in_int (32-bit unsigned; 0x80000000 stays 0x80000000); exp = 158; mag==0 -> DONE with out_float = 0x00000000, zero=1, inexact=0; else NORM.
REQ-015 NORM (FAST_NORM_EN undefined): while mag[31]==0, mag <<= 1 and exp -= 1 per cycle; when mag[31]==1 -> ROUND.
REQ-016 ROUND: mant = mag[30:8], guard = mag[7], sticky = |mag[6:0]; increment mant when guard & (sticky | mant[0]) (round to nearest even); mant carry-out -> mant=0, exp+=1; inexact = guard | sticky; -> DONE.
REQ-017 DONE: out_valid=1, out_float = {sign, exp, mant}; outputs stable while out_ready=0; on out_valid & out_ready -> IDLE next cycle.
REQ-018 Latency from input transfer to out_valid SHALL be 2 cycles for zero, 3 + (leading zeros of mag) otherwise, max 34.
REQ-019 in_valid while not IDLE SHALL be ignored; no overlap of successive conversions.
REQ-020 Results never overflow/underflow: exp range 127..159.

Reset
REQ-021 rst=1 SHALL force IDLE, in_ready=1, out_valid=0, out_float=0, zero=0, inexact=0, internal regs 0, asynchronously.
REQ-022 rst asserted mid-conversion SHALL abandon it; no result emitted after release.

Configuration
REQ-023 Macro FAST_NORM_EN defined: NORM completes in one cycle using leading-zero count (mag <<= lzc, exp = 158 - lzc); latency fixed 4 cycles nonzero, 2 zero.
REQ-024 FAST_NORM_EN undefined: iterative one-bit shift per REQ-015; results bit-identical in both builds.

Structure
REQ-025 Package fp_pkg SHALL hold FP_BIAS=127, INT_EXP_BASE=158, state enum typedef, and IEEE single struct typedef {sign, exp[7:0], mant[22:0]}.
REQ-026 Sub-module lzc32 (32-bit leading-zero counter, 6-bit count) SHALL be instantiated only under FAST_NORM_EN.

Verification
REQ-027 in_int=1, signed -> out_float 0x3F800000, inexact=0, latency 34 (iterative) / 4 (fast).
REQ-028 in_int=0xFFFFFFFF signed -> 0xBF800000; same value unsigned -> 0x4F800000, inexact=1.
REQ-029 in_int=0x80000000 signed -> 0xCF000000, inexact=0; in_int=0 -> 0x00000000, zero=1, out_valid 2 cycles after transfer.
REQ-030 in_int=0x01000001 -> 0x4B800000 inexact=1 (tie to even); 0x01000003 -> 0x4B800002 inexact=1.
REQ-031 out_ready held 0 for 5 cycles in DONE -> out_float stable, in_ready=0, second in_valid ignored; rst pulse during NORM -> out_valid stays 0, in_ready=1 immediately.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared constants and types for the integer to IEEE-754 single converter.
package fp_pkg;

   localparam logic [7:0] FP_BIAS      = 8'd127;
   localparam logic [7:0] INT_EXP_BASE = 8'd158;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ABS   = 3'd1,
      NORM  = 3'd2,
      ROUND = 3'd3,
      DONE  = 3'd4
   } state_e;

   typedef struct packed {
      logic        sign;
      logic [7:0]  exp;
      logic [22:0] mant;
   } ieee_single_t;

endpackage

// File: rtl/lzc32.sv
// 32-bit leading-zero counter; an all-zero input reports 32.
module lzc32 (
   input  logic [31:0] value,
   output logic [5:0]  count
);

   always_comb begin
      count = 6'd32;
      // Scan from LSB up so the highest set bit writes last and wins.
      for (int i = 0; i < 32; i++) begin
         if (value[i]) begin
            count = 6'(31 - i);
         end
      end
   end

endmodule

// File: rtl/int_to_ieee754.sv
// Multi-cycle 32-bit signed/unsigned integer to IEEE-754 single converter.
// Define FAST_NORM_EN to normalise in one step with a leading-zero counter.
module int_to_ieee754
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_int,
   input  logic        in_signed,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_float,
   output logic        zero,
   output logic        inexact
);

   state_e       state_q, state_d;
   logic [31:0]  in_int_q, in_int_d;
   logic         in_signed_q, in_signed_d;
   logic         sign_q, sign_d;
   logic [31:0]  mag_q, mag_d;
   logic [7:0]   exp_q, exp_d;
   logic [22:0]  mant_q, mant_d;
   logic         zero_q, zero_d;
   logic         inexact_q, inexact_d;
   logic         round_inc;
   logic [23:0]  round_sum;
   ieee_single_t result;

`ifdef FAST_NORM_EN
   logic         norm_step_q, norm_step_d;
   logic [5:0]   lzc;

   lzc32 u_lzc (
      .value (mag_q),
      .count (lzc)
   );
`endif

   assign round_inc = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
   assign round_sum = {1'b0, mag_q[30:8]} + {23'd0, round_inc};

   always_comb begin
      state_d     = state_q;
      in_int_d    = in_int_q;
      in_signed_d = in_signed_q;
      sign_d      = sign_q;
      mag_d       = mag_q;
      exp_d       = exp_q;
      mant_d      = mant_q;
      zero_d      = zero_q;
      inexact_d   = inexact_q;
`ifdef FAST_NORM_EN
      norm_step_d = norm_step_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               in_int_d    = in_int;
               in_signed_d = in_signed;
               state_d     = ABS;
            end
         end
         ABS: begin
            sign_d    = in_signed_q & in_int_q[31];
            mag_d     = sign_d ? (~in_int_q + 32'd1) : in_int_q;
            exp_d     = INT_EXP_BASE;
            mant_d    = 23'd0;
            zero_d    = 1'b0;
            inexact_d = 1'b0;
`ifdef FAST_NORM_EN
            norm_step_d = 1'b0;
`endif
            // Zero skips normalisation; an all-zero ROUND pass yields +0 exactly.
            if (in_int_q == 32'd0) begin
               zero_d  = 1'b1;
               exp_d   = 8'd0;
               state_d = ROUND;
            end else begin
               state_d = NORM;
            end
         end
         NORM: begin
`ifdef FAST_NORM_EN
            if (!norm_step_q) begin
               mag_d       = mag_q << lzc;
               exp_d       = INT_EXP_BASE - {2'b00, lzc};
               norm_step_d = 1'b1;
            end else begin
               state_d = ROUND;
            end
`else
            if (mag_q[31]) begin
               state_d = ROUND;
            end else begin
               mag_d = {mag_q[30:0], 1'b0};
               exp_d = exp_q - 8'd1;
            end
`endif
         end
         ROUND: begin
            inexact_d = mag_q[7] | (|mag_q[6:0]);
            if (round_sum[23]) begin
               mant_d = 23'd0;
               exp_d  = exp_q + 8'd1;
            end else begin
               mant_d = round_sum[22:0];
            end
            state_d = DONE;
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         in_int_q    <= 32'd0;
         in_signed_q <= 1'b0;
         sign_q      <= 1'b0;
         mag_q       <= 32'd0;
         exp_q       <= 8'd0;
         mant_q      <= 23'd0;
         zero_q      <= 1'b0;
         inexact_q   <= 1'b0;
`ifdef FAST_NORM_EN
         norm_step_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         in_int_q    <= in_int_d;
         in_signed_q <= in_signed_d;
         sign_q      <= sign_d;
         mag_q       <= mag_d;
         exp_q       <= exp_d;
         mant_q      <= mant_d;
         zero_q      <= zero_d;
         inexact_q   <= inexact_d;
`ifdef FAST_NORM_EN
         norm_step_q <= norm_step_d;
`endif
      end
   end

   assign result.sign = sign_q;
   assign result.exp  = exp_q;
   assign result.mant = mant_q;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_float = out_valid ? result : 32'd0;
   assign zero      = out_valid & zero_q;
   assign inexact   = out_valid & inexact_q;

endmodule

// File: tb/tb_int_to_ieee754.sv
// Directed self-checking bench for int_to_ieee754 (either normaliser build).
module tb_int_to_ieee754;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_int;
   logic        in_signed;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_float;
   logic        zero;
   logic        inexact;

   int compared   = 0;
   int mismatched = 0;

   int_to_ieee754 dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_int    (in_int),
      .in_signed (in_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_float (out_float),
      .zero      (zero),
      .inexact   (inexact)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic int exp_latency(input logic is_zero, input int lz);
      if (is_zero) return 2;
`ifdef FAST_NORM_EN
      return 4;
`else
      return 3 + lz;
`endif
   endfunction

   // Transfer one operand, wait for the result, check it, then retire it.
   task automatic convert(input string tag, input logic [31:0] val, input logic sgn,
                          input logic [31:0] exp_f, input logic exp_z, input logic exp_x,
                          input int lz);
      int cyc;
      @(negedge clk);
      chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
      in_int    = val;
      in_signed = sgn;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_int   = 32'hDEADBEEF;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk({tag, ".latency"}, cyc, exp_latency(exp_z, lz));
      chk({tag, ".float"}, out_float, exp_f);
      chk({tag, ".zero"}, {31'd0, zero}, {31'd0, exp_z});
      chk({tag, ".inexact"}, {31'd0, inexact}, {31'd0, exp_x});
      $display("txn %-10s in=%h signed=%0d -> float=%h zero=%0d inexact=%0d latency=%0d",
               tag, val, sgn, out_float, zero, inexact, cyc);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, ".retire"}, {30'd0, out_valid, in_ready}, 32'd1);
   endtask

   initial begin
      int  cyc;
      logic seen_valid;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_int    = 32'd0;
      in_signed = 1'b0;
      out_ready = 1'b0;
      #2;
      chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
      chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
      chk("reset.out_float", out_float, 32'd0);
      chk("reset.flags", {30'd0, zero, inexact}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      convert("one",      32'h00000001, 1'b1, 32'h3F800000, 1'b0, 1'b0, 31);
      convert("m1_s",     32'hFFFFFFFF, 1'b1, 32'hBF800000, 1'b0, 1'b0, 31);
      convert("ffff_u",   32'hFFFFFFFF, 1'b0, 32'h4F800000, 1'b0, 1'b1, 0);
      convert("minint",   32'h80000000, 1'b1, 32'hCF000000, 1'b0, 1'b0, 0);
      convert("zero",     32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 0);
      convert("tie_even", 32'h01000001, 1'b0, 32'h4B800000, 1'b0, 1'b1, 7);
      convert("tie_up",   32'h01000003, 1'b1, 32'h4B800002, 1'b0, 1'b1, 7);
      convert("24b_max",  32'h00FFFFFF, 1'b0, 32'h4B7FFFFF, 1'b0, 1'b0, 8);
      convert("m5_s",     32'hFFFFFFFB, 1'b1, 32'hC0A00000, 1'b0, 1'b0, 29);
      convert("big_u",    32'hFFFFFFFB, 1'b0, 32'h4F800000, 1'b0, 1'b1, 0);

      // Backpressure in DONE with a competing operand offered meanwhile.
      @(negedge clk);
      in_int    = 32'h00000005;
      in_signed = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_int = 32'h12345678;
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("hold.arrive", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk($sformatf("hold.float%0d", i), out_float, 32'h40A00000);
         chk($sformatf("hold.busy%0d", i), {30'd0, out_valid, in_ready}, 32'd2);
      end
      $display("txn hold       in=00000005 held 5 cycles float=%h", out_float);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("hold.retire", {30'd0, out_valid, in_ready}, 32'd1);

      // Abandon a conversion with an asynchronous reset pulse during NORM.
      @(negedge clk);
      in_int    = 32'h00000001;
      in_signed = 1'b0;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rstmid.in_ready", {31'd0, in_ready}, 32'd1);
      chk("rstmid.out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid) seen_valid = 1'b1;
      end
      chk("rstmid.no_result", {31'd0, seen_valid}, 32'd0);
      chk("rstmid.idle", {31'd0, in_ready}, 32'd1);
      $display("txn rst_mid    abandoned conversion, out_valid seen=%0d", seen_valid);

      convert("after_rst", 32'h00000003, 1'b0, 32'h40400000, 1'b0, 1'b0, 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
